data_sample_packer: RTL and testbench
=====================================

Name: data_sample_packer

Overview:
- Consumer stage directly downstream of the data-clock generator.
- Detects each rising edge of data_clk in the clk domain and captures one sample from the ADC/readout bus on that edge.
- Packs PACK consecutive samples into one wide word and buffers the words in a small FIFO.
- Presents the FIFO to the SDRAM write path through a valid/ready handshake, with overflow accounting.

Parameters:
- SAMPLE_W, 16: width of one sample.
- PACK, 2: samples per output word. Legal range 1..8.
- FIFO_DEPTH, 8: output FIFO entries. Must be a power of 2, at least 2.

Ports:
- clk  input  1  system clock; also the clock that generates data_clk.
- clk_rst  input  1  asynchronous, active-high reset.
- data_clk  input  1  sample-rate clock. It is a register output in the clk domain, so no synchronizer is used.
- enable  input  1  capture enable.
- sample_in  input  SAMPLE_W  sample bus. Stable around each data_clk rising edge.
- out_data  output  SAMPLE_W*PACK  FIFO head word. The first-captured sample is in the LSBs.
- out_valid  output  1  FIFO not empty.
- out_ready  input  1  downstream accepts the head word.
- overflow  output  1  sticky flag: at least one word was dropped.
- drop_cnt  output  16  count of dropped words, saturating.
- sample_cnt  output  32  count of accepted samples, wraps.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset, asynchronous on clk_rst high:
  - dclk_q, slot index, pack register, FIFO pointers and level are all 0.
  - out_valid=0, out_data=0, overflow=0, drop_cnt=0, sample_cnt=0.
  - A reset mid-operation discards any partial word and all FIFO content.
- Edge detect: dclk_q registers data_clk. strobe = data_clk & ~dclk_q. It is one clk cycle wide and fires once per data_clk period. Falling edges are ignored.
- Capture, when strobe=1 and enable=1 at a clk edge:
  - sample_in is written into slot[idx] of the pack register.
  - sample_cnt increments (32-bit wrap).
  - If idx<PACK-1, idx increments.
  - If idx=PACK-1, idx goes to 0 and the completed word is pushed in that same edge. The word is {sample_in, slots PACK-2..0}.
- Latency: with the FIFO empty, out_valid goes high on the edge that completes the word, i.e. it is visible in the cycle after the completing strobe cycle.
- Enable handling:
  - enable=0 suppresses capture; strobes are ignored.
  - On any cycle with enable=0, idx is forced to 0 and the partial word is discarded.
  - The FIFO keeps draining while enable=0.
  - Re-enabling always starts a fresh word at slot 0.
- FIFO:
  - Show-ahead: out_data equals the head entry whenever out_valid=1.
  - Pop occurs when out_valid & out_ready.
  - out_data holds its value while out_valid=1 and out_ready=0.
- Push when full:
  - If a pop happens in the same cycle, the push is accepted and the level is unchanged.
  - Otherwise the word is dropped: overflow is set (sticky until reset) and drop_cnt increments, saturating at 0xFFFF.
  - Dropped samples still count in sample_cnt.
- Push when empty, simultaneous with out_ready: the new word is not popped that cycle, because out_valid was 0.
- Pointers wrap modulo FIFO_DEPTH. fifo_level ranges from 0 to FIFO_DEPTH.
- out_ready with an empty FIFO has no effect.
- PACK=1: every strobe pushes one word.

Decomposition:
- Shared package:
  - SAMPLE_W and PACK defaults.
  - The packed word width, SAMPLE_W*PACK.
  - DROP_CNT_W=16.
  - A log2 helper function.
- One natural sub-module: sync_fifo_fwft.
  - Parameterised width and depth, same clk and clk_rst.
  - Ports: push/din/full and pop/dout/empty/level.
- The packer keeps edge detect, slot counter, counters and the drop logic.

Test Plan:
- Reset check: with the upstream clk_div=3 (data_clk toggles every 4 clk, rising edge every 8 clk), assert reset mid-stream -> all outputs 0 immediately; the first strobe after release lands in slot 0.
- Basic packing: PACK=2, enable=1, out_ready=1, samples 0x1111 then 0x2222 -> one word 0x22221111. out_valid rises 1 cycle after the second strobe and stays high 1 cycle. sample_cnt=2.
- Backpressure and overflow: FIFO_DEPTH=8, out_ready=0, feed 20 samples -> fifo_level=8 and overflow=1 after word 9; drop_cnt=2; sample_cnt=20. Then raise out_ready -> the first 8 words are drained in order, with values intact.
- Full with simultaneous pop: hold the FIFO full and pulse out_ready exactly on the completing strobe cycle -> push accepted, level stays 8, drop_cnt unchanged.
- Enable abort: capture 0xAAAA, drop enable for 1 cycle, re-enable, then capture 0xBBBB and 0xCCCC -> only 0xCCCCBBBB is output; 0xAAAA never appears.
- Saturation: force 70000 drops with a short clk_div -> drop_cnt=0xFFFF and it holds there.

Source files
------------

// File: rtl/data_sample_packer_pkg.sv
// Shared widths and helpers for the data sample packer slice.
package data_sample_packer_pkg;

   localparam int unsigned SAMPLE_W_DEF = 16;
   localparam int unsigned PACK_DEF     = 2;
   localparam int unsigned WORD_W_DEF   = SAMPLE_W_DEF * PACK_DEF;
   localparam int unsigned DROP_CNT_W   = 16;

   function automatic int unsigned log2_ceil(input int unsigned value);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(value)) r++;
      return r;
   endfunction

endpackage

// File: rtl/data_sample_packer_fifo.sv
// First-word-fall-through FIFO: dout shows the head entry whenever empty is low.
module sync_fifo_fwft
   import data_sample_packer_pkg::*;
#(
   parameter int unsigned WIDTH = WORD_W_DEF,
   parameter int unsigned DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       clk_rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           din,
   output logic                       full,
   input  logic                       pop,
   output logic [WIDTH-1:0]           dout,
   output logic                       empty,
   output logic [log2_ceil(DEPTH):0]  level
);

   localparam int unsigned AW    = log2_ceil(DEPTH);
   localparam int unsigned LVL_W = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      level_q, level_d;
   logic             do_push, do_pop;

   assign empty   = (level_q == '0);
   assign full    = (level_q == LVL_W'(DEPTH));
   assign do_pop  = pop & ~empty;
   // A push into a full FIFO is taken only when the head leaves in the same cycle.
   assign do_push = push & (~full | do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk or posedge clk_rst) begin
      if (clk_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

   assign dout  = empty ? '0 : mem_q[rd_ptr_q];
   assign level = level_q;

endmodule

// File: rtl/data_sample_packer.sv
// Captures one sample per data_clk rising edge, packs PACK samples per word and
// queues the words towards the SDRAM write path with drop accounting.
module data_sample_packer
   import data_sample_packer_pkg::*;
#(
   parameter int unsigned SAMPLE_W   = SAMPLE_W_DEF,
   parameter int unsigned PACK       = PACK_DEF,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic                            clk,
   input  logic                            clk_rst,
   input  logic                            data_clk,
   input  logic                            enable,
   input  logic [SAMPLE_W-1:0]             sample_in,
   output logic [SAMPLE_W*PACK-1:0]        out_data,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic                            overflow,
   output logic [DROP_CNT_W-1:0]           drop_cnt,
   output logic [31:0]                     sample_cnt,
   output logic [log2_ceil(FIFO_DEPTH):0]  fifo_level
);

   localparam int unsigned WORD_W = SAMPLE_W * PACK;
   localparam int unsigned IDX_W  = (PACK > 1) ? log2_ceil(PACK) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PACK - 1);

   logic                             dclk_q;
   logic [IDX_W-1:0]                 idx_q, idx_d;
   logic [PACK-1:0][SAMPLE_W-1:0]    slots_q, slots_d;
   logic [31:0]                      sample_cnt_q, sample_cnt_d;
   logic [DROP_CNT_W-1:0]            drop_cnt_q, drop_cnt_d;
   logic                             overflow_q, overflow_d;

   logic                             strobe, capture, complete;
   logic                             fifo_full, fifo_empty, pop, drop;
   logic [WORD_W-1:0]                word;

   assign strobe   = data_clk & ~dclk_q;
   assign capture  = strobe & enable;
   assign complete = capture & (idx_q == LAST_IDX);
   assign pop      = out_valid & out_ready;
   assign drop     = complete & fifo_full & ~pop;

   // The completing sample goes straight from the bus into the top slot of the pushed word.
   always_comb begin
      word = slots_q;
      word[(PACK-1)*SAMPLE_W +: SAMPLE_W] = sample_in;
   end

   always_comb begin
      idx_d        = idx_q;
      slots_d      = slots_q;
      sample_cnt_d = sample_cnt_q;
      drop_cnt_d   = drop_cnt_q;
      overflow_d   = overflow_q;
      if (!enable) begin
         idx_d = '0;
      end else if (capture) begin
         slots_d[idx_q] = sample_in;
         sample_cnt_d   = sample_cnt_q + 32'd1;
         idx_d          = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
      end
      if (drop) begin
         overflow_d = 1'b1;
         if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge clk_rst) begin
      if (clk_rst) begin
         dclk_q       <= 1'b0;
         idx_q        <= '0;
         slots_q      <= '0;
         sample_cnt_q <= '0;
         drop_cnt_q   <= '0;
         overflow_q   <= 1'b0;
      end else begin
         dclk_q       <= data_clk;
         idx_q        <= idx_d;
         slots_q      <= slots_d;
         sample_cnt_q <= sample_cnt_d;
         drop_cnt_q   <= drop_cnt_d;
         overflow_q   <= overflow_d;
      end
   end

   sync_fifo_fwft #(
      .WIDTH (WORD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .clk_rst (clk_rst),
      .push    (complete),
      .din     (word),
      .full    (fifo_full),
      .pop     (pop),
      .dout    (out_data),
      .empty   (fifo_empty),
      .level   (fifo_level)
   );

   assign out_valid  = ~fifo_empty;
   assign overflow   = overflow_q;
   assign drop_cnt   = drop_cnt_q;
   assign sample_cnt = sample_cnt_q;

endmodule

// File: tb/tb_data_sample_packer.sv
// Directed bench for data_sample_packer with SAMPLE_W=16, PACK=2, FIFO_DEPTH=8.
module tb_data_sample_packer;

   logic        clk = 1'b0;
   logic        clk_rst = 1'b1;
   logic        data_clk = 1'b0;
   logic        enable = 1'b0;
   logic        out_ready = 1'b0;
   logic [15:0] sample_in = '0;
   logic [31:0] out_data;
   logic        out_valid;
   logic        overflow;
   logic [15:0] drop_cnt;
   logic [31:0] sample_cnt;
   logic [3:0]  fifo_level;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   data_sample_packer #(
      .SAMPLE_W   (16),
      .PACK       (2),
      .FIFO_DEPTH (8)
   ) dut (
      .clk        (clk),
      .clk_rst    (clk_rst),
      .data_clk   (data_clk),
      .enable     (enable),
      .sample_in  (sample_in),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .overflow   (overflow),
      .drop_cnt   (drop_cnt),
      .sample_cnt (sample_cnt),
      .fifo_level (fifo_level)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic tick(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One data_clk period: high for 'half' clk cycles, then low for 'half'.
   task automatic send(input logic [15:0] s, input int unsigned half);
      data_clk  = 1'b1;
      sample_in = s;
      tick(half);
      data_clk  = 1'b0;
      tick(half);
   endtask

   task automatic do_reset();
      clk_rst   = 1'b1;
      data_clk  = 1'b0;
      out_ready = 1'b0;
      enable    = 1'b0;
      tick(2);
      clk_rst = 1'b0;
      tick(1);
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if (out_valid !== 1'b0 || out_data !== 32'h0 || overflow !== 1'b0 ||
          drop_cnt !== 16'h0 || sample_cnt !== 32'h0 || fifo_level !== 4'd0) begin
         n_fail++;
         $display("FAIL reset_state: valid=%b data=%h ovf=%b drop=%h cnt=%h lvl=%0d, required all 0",
                  out_valid, out_data, overflow, drop_cnt, sample_cnt, fifo_level);
      end
      enable = 1'b1;
      send(16'h0A01, 4);
      send(16'h0A02, 4);
      send(16'h0A03, 4);
      n_checks++;
      if (fifo_level !== 4'd1 || out_data !== 32'h0A020A01 || sample_cnt !== 32'd3) begin
         n_fail++;
         $display("FAIL reset_prestream: lvl=%0d data=%h cnt=%0d, required 1 0a020a01 3",
                  fifo_level, out_data, sample_cnt);
      end
      data_clk  = 1'b1;
      sample_in = 16'h7777;
      #2;
      clk_rst = 1'b1;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || out_data !== 32'h0 || fifo_level !== 4'd0 ||
          sample_cnt !== 32'h0 || drop_cnt !== 16'h0 || overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_async: valid=%b data=%h lvl=%0d cnt=%h drop=%h ovf=%b, required all 0",
                  out_valid, out_data, fifo_level, sample_cnt, drop_cnt, overflow);
      end
      data_clk = 1'b0;
      tick(2);
      clk_rst = 1'b0;
      tick(1);
      send(16'h5555, 4);
      send(16'h6666, 4);
      n_checks++;
      if (fifo_level !== 4'd1 || out_data !== 32'h66665555 || sample_cnt !== 32'd2) begin
         n_fail++;
         $display("FAIL reset_slot0: lvl=%0d data=%h cnt=%0d, required 1 66665555 2",
                  fifo_level, out_data, sample_cnt);
      end
   endtask

   task automatic test_basic_packing();
      do_reset();
      enable    = 1'b1;
      out_ready = 1'b1;
      send(16'h1111, 1);
      data_clk  = 1'b1;
      sample_in = 16'h2222;
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_early_valid: valid=%b, required 0", out_valid);
      end
      tick(1);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h22221111) begin
         n_fail++;
         $display("FAIL basic_word: valid=%b data=%h, required 1 22221111", out_valid, out_data);
      end
      data_clk = 1'b0;
      tick(1);
      n_checks++;
      if (out_valid !== 1'b0 || sample_cnt !== 32'd2 || fifo_level !== 4'd0) begin
         n_fail++;
         $display("FAIL basic_after_pop: valid=%b cnt=%0d lvl=%0d, required 0 2 0",
                  out_valid, sample_cnt, fifo_level);
      end
      out_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      logic [31:0] exp;
      do_reset();
      enable = 1'b1;
      for (int unsigned i = 0; i < 16; i++) send(16'(16'h0100 + i), 1);
      n_checks++;
      if (fifo_level !== 4'd8 || overflow !== 1'b0 || drop_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL bp_full: lvl=%0d ovf=%b drop=%0d, required 8 0 0", fifo_level, overflow, drop_cnt);
      end
      for (int unsigned i = 16; i < 18; i++) send(16'(16'h0100 + i), 1);
      n_checks++;
      if (overflow !== 1'b1 || drop_cnt !== 16'd1 || fifo_level !== 4'd8) begin
         n_fail++;
         $display("FAIL bp_word9: ovf=%b drop=%0d lvl=%0d, required 1 1 8", overflow, drop_cnt, fifo_level);
      end
      for (int unsigned i = 18; i < 20; i++) send(16'(16'h0100 + i), 1);
      n_checks++;
      if (drop_cnt !== 16'd2 || sample_cnt !== 32'd20 || fifo_level !== 4'd8 || overflow !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_word10: drop=%0d cnt=%0d lvl=%0d ovf=%b, required 2 20 8 1",
                  drop_cnt, sample_cnt, fifo_level, overflow);
      end
      out_ready = 1'b1;
      for (int unsigned k = 0; k < 8; k++) begin
         exp = {16'(16'h0100 + 2*k + 1), 16'(16'h0100 + 2*k)};
         n_checks++;
         if (out_valid !== 1'b1 || out_data !== exp) begin
            n_fail++;
            $display("FAIL bp_drain[%0d]: valid=%b data=%h, required 1 %h", k, out_valid, out_data, exp);
         end
         tick(1);
      end
      out_ready = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0 || fifo_level !== 4'd0 || overflow !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_empty: valid=%b lvl=%0d ovf=%b, required 0 0 1", out_valid, fifo_level, overflow);
      end
   endtask

   task automatic test_full_pop();
      logic [31:0] exp;
      do_reset();
      enable = 1'b1;
      for (int unsigned i = 0; i < 16; i++) send(16'(16'h2000 + i), 1);
      send(16'hA0A0, 1);
      data_clk  = 1'b1;
      sample_in = 16'hB0B0;
      out_ready = 1'b1;
      tick(1);
      out_ready = 1'b0;
      n_checks++;
      if (fifo_level !== 4'd8 || drop_cnt !== 16'd0 || overflow !== 1'b0 || out_data !== 32'h20032002) begin
         n_fail++;
         $display("FAIL fullpop_accept: lvl=%0d drop=%0d ovf=%b head=%h, required 8 0 0 20032002",
                  fifo_level, drop_cnt, overflow, out_data);
      end
      data_clk = 1'b0;
      tick(1);
      out_ready = 1'b1;
      for (int unsigned k = 0; k < 8; k++) begin
         exp = (k == 7) ? 32'hB0B0A0A0 : {16'(16'h2000 + 2*(k+1) + 1), 16'(16'h2000 + 2*(k+1))};
         n_checks++;
         if (out_valid !== 1'b1 || out_data !== exp) begin
            n_fail++;
            $display("FAIL fullpop_drain[%0d]: valid=%b data=%h, required 1 %h", k, out_valid, out_data, exp);
         end
         tick(1);
      end
      out_ready = 1'b0;
   endtask

   task automatic test_enable_abort();
      do_reset();
      enable = 1'b1;
      send(16'hAAAA, 1);
      enable = 1'b0;
      tick(1);
      enable = 1'b1;
      send(16'hBBBB, 1);
      send(16'hCCCC, 1);
      n_checks++;
      if (fifo_level !== 4'd1 || out_data !== 32'hCCCCBBBB || sample_cnt !== 32'd3) begin
         n_fail++;
         $display("FAIL abort_word: lvl=%0d data=%h cnt=%0d, required 1 ccccbbbb 3",
                  fifo_level, out_data, sample_cnt);
      end
      enable = 1'b0;
      send(16'hDDDD, 1);
      send(16'hEEEE, 1);
      n_checks++;
      if (fifo_level !== 4'd1 || sample_cnt !== 32'd3) begin
         n_fail++;
         $display("FAIL abort_disabled: lvl=%0d cnt=%0d, required 1 3", fifo_level, sample_cnt);
      end
      enable = 1'b1;
   endtask

   task automatic test_saturation();
      do_reset();
      enable = 1'b1;
      for (int unsigned i = 0; i < 16; i++) send(16'(16'h3000 + i), 1);
      // Preload the counter close to its ceiling rather than dropping 65k real words.
      force dut.drop_cnt_q = 16'hFFFC;
      tick(1);
      release dut.drop_cnt_q;
      n_checks++;
      if (drop_cnt !== 16'hFFFC) begin
         n_fail++;
         $display("FAIL sat_preload: drop=%h, required fffc", drop_cnt);
      end
      for (int unsigned i = 0; i < 6; i++) send(16'(16'h3100 + i), 1);
      n_checks++;
      if (drop_cnt !== 16'hFFFF || overflow !== 1'b1) begin
         n_fail++;
         $display("FAIL sat_reach: drop=%h ovf=%b, required ffff 1", drop_cnt, overflow);
      end
      for (int unsigned i = 0; i < 6; i++) send(16'(16'h3200 + i), 1);
      n_checks++;
      if (drop_cnt !== 16'hFFFF || sample_cnt !== 32'd28 || fifo_level !== 4'd8) begin
         n_fail++;
         $display("FAIL sat_hold: drop=%h cnt=%0d lvl=%0d, required ffff 28 8", drop_cnt, sample_cnt, fifo_level);
      end
   endtask

   initial begin
      test_reset();
      test_basic_packing();
      test_backpressure();
      test_full_pop();
      test_enable_abort();
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
